irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 31, SHALL set the number of external interrupt inputs (1..32).
REQ-002 Parameter VEC_W, default 5, SHALL set the vector width; VEC_W SHALL be at least clog2(N_IRQ).
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_ext  input  N_IRQ  SHALL carry the asynchronous external interrupt lines, active-high.
REQ-006 cfg_we  input  1  SHALL be the register write strobe, one Clk cycle per write.
REQ-007 cfg_addr  input  2  SHALL select the register: 0 MASK, 1 MODE, 2 PEND, 3 INSV.
REQ-008 cfg_wdata  input  32  SHALL carry the write data; bits at N_IRQ and above are ignored.
REQ-009 cfg_rdata  output  32  SHALL return the selected register combinationally, zero-extended.
REQ-010 irq_req  output  1  SHALL be the registered interrupt request to the CPU.
REQ-011 irq_vec  output  VEC_W  SHALL be the registered index of the requested channel.
REQ-012 irq_ack  input  1  SHALL be the CPU acknowledge, one-cycle pulse.
REQ-013 irq_eoi  input  1  SHALL be the CPU end-of-interrupt, one-cycle pulse.

Function
REQ-014 Each i_ext bit SHALL pass a 2-flop synchroniser plus one history flop; input pulses shorter than one Clk period MAY be lost.
REQ-015 MODE bit = 1 (edge) SHALL set PEND[k] on a synchronised 0->1 of i_ext[k]; PEND[k] then SHALL hold until cleared.
REQ-016 MODE bit = 0 (level) SHALL make PEND[k] follow synchronised i_ext[k]; writes SHALL NOT clear it.
REQ-017 An i_ext rise stable before Clk edge t SHALL appear in PEND after edge t+2, and irq_req SHALL be high after edge t+3 if the channel is unmasked and the FSM is IDLE.
REQ-018 Writing 1 to a PEND bit SHALL clear that bit for edge-mode channels; writing 0 SHALL have no effect.
REQ-019 MASK bit = 1 SHALL enable a channel; masking SHALL NOT clear PEND.
REQ-020 Priority SHALL be fixed: the lowest index has the highest priority.
REQ-021 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-022 IDLE -> REQ SHALL occur when (PEND & MASK) != 0; the FSM SHALL latch irq_vec as the highest-priority such channel and assert irq_req.
REQ-023 While in REQ, irq_vec SHALL stay stable; a newly pending higher-priority channel SHALL NOT change it.
REQ-024 In REQ, if the latched channel becomes masked or its PEND bit is 0 before an ack, the FSM SHALL return to IDLE, deassert irq_req and re-arbitrate the following cycle.
REQ-025 REQ -> SERVICE on irq_ack SHALL deassert irq_req, set INSV[irq_vec], and clear PEND[irq_vec] if that channel is edge-mode.
REQ-026 SERVICE -> IDLE on irq_eoi SHALL clear INSV; irq_eoi outside SERVICE and irq_ack outside REQ SHALL be ignored.
REQ-027 If a synchronised edge and an ack/PEND-clear hit the same channel in one cycle, the set SHALL win.
REQ-028 The design SHALL not support nesting: no new request SHALL issue while in SERVICE; pending channels SHALL wait.
REQ-029 INSV SHALL be read-only (one-hot or zero); MODE and MASK SHALL be read/write.

Reset
REQ-030 When Rst is low, the block SHALL asynchronously force irq_req=0, irq_vec=0, MASK=0, MODE=all ones (edge), PEND=0, INSV=0, all synchroniser flops 0, and FSM=IDLE.
REQ-031 Reset asserted mid-REQ or mid-SERVICE SHALL discard all pending and in-service state; no request SHALL follow release without a new input edge.

Structure
REQ-032 A shared package SHALL hold the register address constants, FSM state encodings, and the default N_IRQ/VEC_W values.
REQ-033 A priority-encoder sub-module, irq_prio_enc (N_IRQ in, VEC_W index plus a valid flag out, combinational), SHALL be instantiated once.

Verification
REQ-034 Single edge: MASK=all ones; i_ext[1] 0->1 held 4 cycles -> irq_req=1, irq_vec=1 three edges after sampling; ack -> PEND[1]=0, INSV=0x2; eoi -> INSV=0, FSM IDLE.
REQ-035 Priority: i_ext[8] and i_ext[2] rise in the same cycle -> irq_vec=2 first; after ack and eoi -> irq_vec=8.
REQ-036 Level mode: MODE[3]=0; hold i_ext[3]=1 -> request; after ack and eoi the request recurs; drop i_ext[3] -> no further request.
REQ-037 Mask withdraw: request on channel 5 pending; write MASK[5]=0 before ack -> irq_req=0 next cycle and PEND[5] stays 1; unmask -> request again.
REQ-038 Glitch and reset: a 4 ns pulse on a 10 ns Clk may be missed but SHALL never raise two requests; Rst low during SERVICE -> all registers return to reset values immediately.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the interrupt controller.
package irq_ctrl_pkg;

  localparam int unsigned DEF_N_IRQ = 31;
  localparam int unsigned DEF_VEC_W = 5;
  localparam int unsigned CFG_DW    = 32;

  // Configuration register map
  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_MODE = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_INSV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ = DEF_N_IRQ,
  parameter int unsigned VEC_W = DEF_VEC_W
) (
  input  logic [N_IRQ-1:0] req,
  output logic [VEC_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest active index is the last assignment
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = VEC_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised inputs, edge/level pending, fixed priority, single in-service.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ = DEF_N_IRQ,
  parameter int unsigned VEC_W = DEF_VEC_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_IRQ-1:0]  i_ext,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [CFG_DW-1:0] cfg_wdata,
  output logic [CFG_DW-1:0] cfg_rdata,
  output logic              irq_req,
  output logic [VEC_W-1:0]  irq_vec,
  input  logic              irq_ack,
  input  logic              irq_eoi
);

  logic [N_IRQ-1:0] sync1, sync2, hist;
  logic [N_IRQ-1:0] mask_q, mode_q, pend_q, insv_q;
  logic [N_IRQ-1:0] pend_d, insv_d, clr, rise, vec_onehot, wdata_n;
  logic [VEC_W-1:0] enc_idx, vec_d;
  logic             enc_valid, req_d, ack_hit, eoi_hit;
  irq_state_e       state_q, state_d;
  logic             unused_wdata;

  assign wdata_n      = cfg_wdata[N_IRQ-1:0];
  assign unused_wdata = ^cfg_wdata;
  assign rise         = sync2 & ~hist;
  assign vec_onehot   = N_IRQ'(1) << irq_vec;

  irq_prio_enc #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) u_prio_enc (
    .req   (pend_q & mask_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Two-flop synchroniser plus history flop for edge detection
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= i_ext;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // MASK and MODE configuration registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mask_q <= '0;
      mode_q <= '1;
    end else if (cfg_we) begin
      if (cfg_addr == ADDR_MASK) mask_q <= wdata_n;
      if (cfg_addr == ADDR_MODE) mode_q <= wdata_n;
    end
  end

  // Next-state and registered-output logic of the request FSM
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    vec_d   = irq_vec;
    ack_hit = 1'b0;
    eoi_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          vec_d   = enc_idx;
        end
      end
      ST_REQ: begin
        // Withdrawn request (masked or no longer pending) drops back to arbitrate again
        if (!(pend_q[irq_vec] && mask_q[irq_vec])) begin
          state_d = ST_IDLE;
        end else if (irq_ack) begin
          state_d = ST_SERVICE;
          ack_hit = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (irq_eoi) begin
          state_d = ST_IDLE;
          eoi_hit = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending/in-service next values; a new edge outranks any clear
  always_comb begin
    clr = '0;
    if (cfg_we && (cfg_addr == ADDR_PEND)) clr = wdata_n;
    if (ack_hit) clr = clr | vec_onehot;
    pend_d = (mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & sync2);
    insv_d = insv_q;
    if (ack_hit) insv_d = vec_onehot;
    else if (eoi_hit) insv_d = '0;
  end

  // FSM state and CPU-facing outputs
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      irq_req <= 1'b0;
      irq_vec <= '0;
    end else begin
      state_q <= state_d;
      irq_req <= req_d;
      irq_vec <= vec_d;
    end
  end

  // PEND and INSV status registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pend_q <= '0;
      insv_q <= '0;
    end else begin
      pend_q <= pend_d;
      insv_q <= insv_d;
    end
  end

  // Combinational register readback, zero-extended
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK: cfg_rdata = CFG_DW'(mask_q);
      ADDR_MODE: cfg_rdata = CFG_DW'(mode_q);
      ADDR_PEND: cfg_rdata = CFG_DW'(pend_q);
      ADDR_INSV: cfg_rdata = CFG_DW'(insv_q);
      default:   cfg_rdata = '0;
    endcase
  end

endmodule
